scramble: RTL and testbench
===========================

SCRAMBLE -- requirements
Module: scramble

Interface
REQ-001 The block SHALL have the parameter PREAMBLE_LEN, default 64, meaning the number of preamble words per frame.
REQ-002 The block SHALL have the parameter PAYLOAD_LEN, default 1024, meaning the number of payload words per frame.
REQ-003 The block SHALL have the parameter SEED, default 15'h7FFF, meaning the LFSR load value at each frame start.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have the port start, input, 1 bit: frame request, sampled only in IDLE.
REQ-007 The block SHALL have the port data_in, input, 16 bits: plaintext payload word.
REQ-008 The block SHALL have the port in_valid, input, 1 bit: data_in is valid this cycle.
REQ-009 The block SHALL have the port in_ready, output, 1 bit: the block accepts data_in this cycle.
REQ-010 The block SHALL have the port scramble_data, output, 16 bits: registered output word, either preamble or scrambled payload.
REQ-011 The block SHALL have the port data_valid, output, 1 bit: scramble_data is valid this cycle.
REQ-012 The block SHALL have the port frame_done, output, 1 bit: one-cycle pulse after the last payload word.

Function
REQ-013 The FSM SHALL have the states IDLE, PREAMBLE and PAYLOAD.
REQ-014 IDLE SHALL go to PREAMBLE on start=1; the preamble word counter SHALL clear to 0 and the LFSR SHALL load SEED.
REQ-015 PREAMBLE SHALL emit one word per cycle with data_valid=1 and in_ready=0: words 0..PREAMBLE_LEN-2 SHALL be 16'h5555 and the last word SHALL be 16'hD5D5 (start-of-frame delimiter).
REQ-016 After the last preamble word the FSM SHALL enter PAYLOAD with the payload counter at 0.
REQ-017 PAYLOAD SHALL hold in_ready=1; a word is accepted when in_valid=1 and in_ready=1.
REQ-018 An accepted word SHALL appear on scramble_data with data_valid=1 exactly one cycle after acceptance; a non-accept cycle SHALL give data_valid=0 the next cycle and leave the LFSR and counter unchanged.
REQ-019 Scrambling SHALL be additive PRBS15 (x^15+x^14+1), 15-bit state L, 16 serial steps per accepted word, MSB first.
REQ-020 Each serial step n=0..15 SHALL compute key=L[14]^L[13], set out[15-n]=data_in[15-n]^key, then set L={L[13:0],key}.
REQ-021 All 16 steps SHALL complete combinationally within one cycle, and the LFSR SHALL advance exactly 16 steps per accepted word.
REQ-022 On the cycle of the PAYLOAD_LEN-th acceptance the FSM SHALL return to IDLE and in_ready SHALL drop to 0 the next cycle.
REQ-023 frame_done SHALL pulse high concurrently with that last word's data_valid.
REQ-024 start SHALL be ignored in PREAMBLE and PAYLOAD.
REQ-025 start=1 on the cycle the FSM returns to IDLE SHALL begin a new frame the next cycle, with no gap beyond one IDLE cycle.
REQ-026 There SHALL be no output backpressure; the consumer SHALL always accept data_valid words.
REQ-027 Counters SHALL be sized to hold PREAMBLE_LEN-1 and PAYLOAD_LEN-1, and SHALL never wrap within a frame.
REQ-028 A frame SHALL be PREAMBLE_LEN+PAYLOAD_LEN output words (1088 by default).

Reset
REQ-029 While reset=1, regardless of clk, the block SHALL hold FSM=IDLE, counters=0, L=SEED, scramble_data=16'h0000, data_valid=0, in_ready=0, frame_done=0.
REQ-030 A reset asserted mid-frame SHALL abort the frame immediately with no further data_valid, and the next start SHALL produce a complete fresh frame.

Verification
REQ-031 A bench SHALL cover: reset, then start pulse -> 63 words 16'h5555 then 16'hD5D5 on consecutive cycles, in_ready=0 throughout.
REQ-032 A bench SHALL cover: default SEED, first payload word 16'h0000 -> scramble_data=16'h0002 one cycle after acceptance.
REQ-033 A bench SHALL cover: 1024 payload words streamed continuously -> 1088 total data_valid cycles, frame_done on the last, in_ready=0 the next cycle; applying the same PRBS15 descrambling to the payload reproduces the input exactly.
REQ-034 A bench SHALL cover: in_valid toggled randomly -> data_valid gaps mirror the acceptance gaps one cycle later, and the scrambled sequence is identical to the continuous run.
REQ-035 A bench SHALL cover: start held high during PREAMBLE/PAYLOAD -> no restart, frame intact; start held across frame end -> second frame begins after one IDLE cycle with L reloaded (word 0 of 16'h0000 -> 16'h0002).
REQ-036 A bench SHALL cover: reset pulsed mid-payload (word 500) asynchronously between clock edges -> outputs zero immediately; a subsequent frame matches a clean-run golden file.

Source files
------------

// File: rtl/scramble.sv
// Frame generator: fixed preamble with start-of-frame delimiter, then a payload
// additively scrambled with PRBS15 (x^15+x^14+1), 16 serial steps per word.
module scramble #(
    parameter int          PREAMBLE_LEN = 64,
    parameter int          PAYLOAD_LEN  = 1024,
    parameter logic [14:0] SEED         = 15'h7FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] data_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] scramble_data,
    output logic        data_valid,
    output logic        frame_done
);

    localparam int DATA_W = 16;
    localparam int LFSR_W = 15;
    localparam int PRE_W  = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
    localparam int PAY_W  = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);
    localparam logic [PAY_W-1:0]  PAY_LAST = PAY_W'(PAYLOAD_LEN - 1);
    localparam logic [DATA_W-1:0] PRE_WORD = 16'h5555;
    localparam logic [DATA_W-1:0] SFD_WORD = 16'hD5D5;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD
    } state_t;

    state_t              state_q,     state_d;
    logic [PRE_W-1:0]    pre_cnt_q,   pre_cnt_d;
    logic [PAY_W-1:0]    pay_cnt_q,   pay_cnt_d;
    logic [LFSR_W-1:0]   lfsr_q,      lfsr_d;
    logic [DATA_W-1:0]   sdata_q,     sdata_d;
    logic                dvalid_q,    dvalid_d;
    logic                in_ready_q,  in_ready_d;
    logic                done_q,      done_d;

    logic [LFSR_W-1:0]   lfsr_adv;
    logic [DATA_W-1:0]   scr_word;
    logic [PRE_W-1:0]    pre_nxt;
    logic                accept;

    function automatic logic [DATA_W-1:0] preamble_word(input logic [PRE_W-1:0] idx);
        return (idx == PRE_LAST) ? SFD_WORD : PRE_WORD;
    endfunction

    // Unrolled serial scrambler: returns {advanced LFSR, scrambled word}, MSB processed first.
    function automatic logic [LFSR_W+DATA_W-1:0] prbs15_scramble(
        input logic [DATA_W-1:0] din,
        input logic [LFSR_W-1:0] lin
    );
        logic [LFSR_W-1:0] l;
        logic [DATA_W-1:0] o;
        logic              key;
        l = lin;
        o = '0;
        for (int n = 0; n < DATA_W; n++) begin
            key            = l[14] ^ l[13];
            o[DATA_W-1-n]  = din[DATA_W-1-n] ^ key;
            l              = {l[13:0], key};
        end
        return {l, o};
    endfunction

    assign {lfsr_adv, scr_word} = prbs15_scramble(data_in, lfsr_q);
    assign pre_nxt = pre_cnt_q + 1'b1;
    assign accept  = in_valid && in_ready_q;

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        pay_cnt_d = pay_cnt_q;
        lfsr_d    = lfsr_q;
        sdata_d   = sdata_q;
        dvalid_d  = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = PREAMBLE;
                    pre_cnt_d = '0;
                    pay_cnt_d = '0;
                    lfsr_d    = SEED;
                    sdata_d   = preamble_word('0);
                    dvalid_d  = 1'b1;
                end
            end
            PREAMBLE: begin
                // pre_cnt_q indexes the word currently on the output register
                if (pre_cnt_q == PRE_LAST) begin
                    state_d   = PAYLOAD;
                    pre_cnt_d = '0;
                    pay_cnt_d = '0;
                end else begin
                    pre_cnt_d = pre_nxt;
                    sdata_d   = preamble_word(pre_nxt);
                    dvalid_d  = 1'b1;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    sdata_d  = scr_word;
                    dvalid_d = 1'b1;
                    lfsr_d   = lfsr_adv;
                    if (pay_cnt_q == PAY_LAST) begin
                        state_d   = IDLE;
                        pay_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        pay_cnt_d = pay_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == PAYLOAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pre_cnt_q  <= '0;
            pay_cnt_q  <= '0;
            lfsr_q     <= SEED;
            sdata_q    <= '0;
            dvalid_q   <= 1'b0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            pay_cnt_q  <= pay_cnt_d;
            lfsr_q     <= lfsr_d;
            sdata_q    <= sdata_d;
            dvalid_q   <= dvalid_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign scramble_data = sdata_q;
    assign data_valid    = dvalid_q;
    assign frame_done    = done_q;

endmodule

// File: tb/tb_scramble.sv
// Randomized frame-level bench for scramble against a keystream-sequence model.
module tb_scramble;

    localparam int PRE = 64;
    localparam int PAY = 1024;
    localparam int KS_LEN = 15 + 16 * PAY;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] scramble_data;
    logic        data_valid;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] key_word  [PAY];
    logic [15:0] pay_data  [PAY];
    logic [15:0] gold      [PAY];
    logic [15:0] got_words [PAY];
    bit          ks        [KS_LEN];

    scramble dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .data_in       (data_in),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .scramble_data (scramble_data),
        .data_valid    (data_valid),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Keystream as a bit sequence: x[n] = x[n-15] ^ x[n-14], seeded with the 15 seed bits.
    task automatic build_keys();
        logic [14:0] seed;
        seed = 15'h7FFF;
        for (int i = 0; i < 15; i++) ks[i] = seed[14-i];
        for (int n = 15; n < KS_LEN; n++) ks[n] = ks[n-15] ^ ks[n-14];
        for (int j = 0; j < PAY; j++)
            for (int m = 0; m < 16; m++)
                key_word[j][15-m] = ks[15 + 16*j + m];
    endtask

    task automatic run_frame(input int vpct, input bit hold, input int abort_at, output int dv_count);
        int          j;
        int          cyc;
        bit          acc_prev;
        logic [15:0] exp_prev;
        dv_count = 0;
        acc_prev = 1'b0;
        exp_prev = '0;
        j        = 0;
        cyc      = 0;
        start    = 1'b1;
        in_valid = 1'b0;
        tick();
        if (!hold) start = 1'b0;
        for (int k = 0; k < PRE; k++) begin
            chk("pre_valid", data_valid, 1);
            chk("pre_word", scramble_data, (k == PRE-1) ? 16'hD5D5 : 16'h5555);
            chk("pre_ready", in_ready, 0);
            dv_count += data_valid;
            tick();
        end
        while (1) begin
            chk("pay_valid", data_valid, acc_prev);
            if (acc_prev) begin
                chk("pay_word", scramble_data, exp_prev);
                got_words[j-1] = scramble_data;
            end
            chk("pay_done", frame_done, acc_prev && (j == PAY));
            chk("pay_ready", in_ready, j < PAY);
            dv_count += data_valid;
            if (j == PAY) break;
            if (j == abort_at) begin
                #2 reset = 1'b1;
                #1;
                chk("abort_valid", data_valid, 0);
                chk("abort_data", scramble_data, 0);
                chk("abort_ready", in_ready, 0);
                chk("abort_done", frame_done, 0);
                in_valid = 1'b0;
                start    = 1'b0;
                tick();
                chk("abort_hold_valid", data_valid, 0);
                #3 reset = 1'b0;
                for (int r = 0; r < 3; r++) begin
                    tick();
                    chk("post_abort_valid", data_valid, 0);
                end
                return;
            end
            if (cyc > 20 * PAY) begin
                chk("payload_timeout", 1, 0);
                in_valid = 1'b0;
                return;
            end
            in_valid = ($urandom_range(99) < vpct);
            data_in  = in_valid ? pay_data[j] : 16'($urandom);
            acc_prev = in_valid;
            exp_prev = pay_data[j] ^ key_word[j];
            if (in_valid) j++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
    endtask

    function automatic int gold_diff();
        int d = 0;
        for (int i = 0; i < PAY; i++) if (got_words[i] !== gold[i]) d++;
        return d;
    endfunction

    initial begin
        int dv;
        int errs;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        build_keys();
        pay_data[0] = 16'h0000;
        for (int i = 1; i < PAY; i++) pay_data[i] = 16'($urandom);

        repeat (3) tick();
        chk("rst_valid", data_valid, 0);
        chk("rst_data", scramble_data, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_done", frame_done, 0);
        #3 reset = 1'b0;
        tick();
        chk("idle_valid", data_valid, 0);
        chk("idle_ready", in_ready, 0);

        // Continuous reference frame
        run_frame(100, 1'b0, -1, dv);
        chk("a_dv_count", dv, PRE + PAY);
        chk("a_first_word", got_words[0], 16'h0002);
        errs = 0;
        for (int i = 0; i < PAY; i++) if ((got_words[i] ^ key_word[i]) !== pay_data[i]) errs++;
        chk("a_descramble", errs, 0);
        gold = got_words;
        tick();
        chk("a_idle_valid", data_valid, 0);
        chk("a_idle_ready", in_ready, 0);

        // Gapped input with start held through the frame and across its end
        run_frame(50, 1'b1, -1, dv);
        chk("b_dv_count", dv, PRE + PAY);
        chk("b_vs_gold", gold_diff(), 0);

        // Back-to-back frame after a single idle cycle
        run_frame(100, 1'b0, -1, dv);
        chk("c_dv_count", dv, PRE + PAY);
        chk("c_first_word", got_words[0], 16'h0002);
        chk("c_vs_gold", gold_diff(), 0);

        // Mid-payload asynchronous reset, then a fresh frame
        run_frame(70, 1'b0, 500, dv);
        run_frame(100, 1'b0, -1, dv);
        chk("e_dv_count", dv, PRE + PAY);
        chk("e_vs_gold", gold_diff(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
